// File: rtl/adc_ctrl_rx.sv
// rtl/adc_ctrl_rx.sv - LiteDTU S3 ADC power-up/calibration sequencer and sample receiver
// Optional SEU flag counter: define ADC_RX_SEU_CNT_EN to build it, otherwise seu_count is tied to 0.
module adc_ctrl_rx #(
   parameter int PUP_WAIT     = 16,
   parameter int CAL_PULSE    = 4,
   parameter int CAL_START_TO = 64,
   parameter int CAL_TIMEOUT  = 30000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        cal_req,
   input  logic        df_twos,
   input  logic [11:0] adc_d,
   input  logic        adc_ovf,
   input  logic        adc_cal_busy,
   input  logic        adc_seu,
   output logic        OM_A,
   output logic        OM_B,
   output logic        OM_C,
   output logic        CAL_A,
   output logic        CAL_B,
   output logic        CAL_C,
   output logic        DF_A,
   output logic        DF_B,
   output logic        DF_C,
   output logic [11:0] data_out,
   output logic        data_valid,
   output logic        ovf_out,
   output logic        ready,
   output logic        error,
   output logic [7:0]  seu_count
);
   typedef enum logic [2:0] {
      OFF, PWRUP, CAL_PULSE_S, CAL_WAIT_HI, CAL_WAIT_LO, RUN, ERR
   } state_t;

   localparam logic [15:0] PUP_LAST   = 16'(PUP_WAIT - 1);
   localparam logic [15:0] PULSE_LAST = 16'(CAL_PULSE - 1);
   localparam logic [15:0] START_LAST = 16'(CAL_START_TO - 1);
   localparam logic [15:0] BUSY_LAST  = 16'(CAL_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        df_q, df_d;
   logic        om_q, cal_q, ready_q, error_q, valid_q, ovf_q;
   logic        valid_d;
   logic [11:0] s1_d_q, dout_q;
   logic        s1_ovf_q, s1_busy_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         OFF:         if (en) state_d = PWRUP;
         PWRUP:       if (cnt_q == PUP_LAST) state_d = CAL_PULSE_S;
         CAL_PULSE_S: if (cnt_q == PULSE_LAST) state_d = CAL_WAIT_HI;
         // the expected busy edge takes priority over an expiring timeout
         CAL_WAIT_HI: begin
            if (adc_cal_busy)             state_d = CAL_WAIT_LO;
            else if (cnt_q == START_LAST) state_d = ERR;
         end
         CAL_WAIT_LO: begin
            if (!adc_cal_busy)           state_d = RUN;
            else if (cnt_q == BUSY_LAST) state_d = ERR;
         end
         RUN: begin
            if (cal_req)           state_d = CAL_PULSE_S;
            else if (adc_cal_busy) state_d = CAL_WAIT_LO;
         end
         ERR:         if (cal_req) state_d = CAL_PULSE_S;
         default:     state_d = OFF;
      endcase
      if (!en) state_d = OFF;
   end

   always_comb begin
      cnt_d   = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      df_d    = (state_q == OFF) ? df_twos : df_q;
      valid_d = (state_d == RUN) && !adc_cal_busy;
   end

   // Control pins and status are registered from the next state so they change with it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= OFF;
         cnt_q     <= 16'd0;
         df_q      <= 1'b0;
         om_q      <= 1'b0;
         cal_q     <= 1'b0;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         s1_d_q    <= 12'd0;
         s1_ovf_q  <= 1'b0;
         s1_busy_q <= 1'b0;
         dout_q    <= 12'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         df_q      <= df_d;
         om_q      <= (state_d != OFF);
         cal_q     <= (state_d == CAL_PULSE_S);
         ready_q   <= (state_d == RUN);
         error_q   <= (state_d == ERR);
         valid_q   <= valid_d;
         ovf_q     <= s1_ovf_q && valid_d;
         s1_d_q    <= adc_d;
         s1_ovf_q  <= adc_ovf;
         s1_busy_q <= adc_cal_busy;
         dout_q    <= s1_d_q ^ (df_q ? 12'h800 : 12'h000);
      end
   end

`ifdef ADC_RX_SEU_CNT_EN
   logic       seu_s1_q, seu_s2_q;
   logic [7:0] seu_cnt_q, seu_cnt_d;

   always_comb begin
      seu_cnt_d = seu_cnt_q;
      if (seu_s1_q && !seu_s2_q && (seu_cnt_q != 8'hFF)) seu_cnt_d = seu_cnt_q + 8'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         seu_s1_q  <= 1'b0;
         seu_s2_q  <= 1'b0;
         seu_cnt_q <= 8'd0;
      end else begin
         seu_s1_q  <= adc_seu;
         seu_s2_q  <= seu_s1_q;
         seu_cnt_q <= seu_cnt_d;
      end
   end

   assign seu_count = seu_cnt_q;
`else
   logic unused_seu;
   assign unused_seu = adc_seu;
   assign seu_count  = 8'd0;
`endif

   logic unused_busy;
   assign unused_busy = s1_busy_q;

   assign {OM_A, OM_B, OM_C}    = {3{om_q}};
   assign {CAL_A, CAL_B, CAL_C} = {3{cal_q}};
   assign {DF_A, DF_B, DF_C}    = {3{df_q}};
   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign ovf_out    = ovf_q;
   assign ready      = ready_q;
   assign error      = error_q;
endmodule

// File: tb/tb_adc_ctrl_rx.sv
// tb/tb_adc_ctrl_rx.sv - scoreboard bench for adc_ctrl_rx (PUP_WAIT=4, CAL_PULSE=2, CAL_START_TO=8, CAL_TIMEOUT=50)
module tb_adc_ctrl_rx;
   logic        CLK = 1'b0;
   logic        RST, en, cal_req, df_twos, adc_ovf, adc_cal_busy, adc_seu;
   logic [11:0] adc_d;
   logic        OM_A, OM_B, OM_C, CAL_A, CAL_B, CAL_C, DF_A, DF_B, DF_C;
   logic [11:0] data_out;
   logic        data_valid, ovf_out, ready, error;
   logic [7:0]  seu_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic [11:0] d;
      logic        ovf;
   } exp_t;
   exp_t sb_q[$];

`ifdef ADC_RX_SEU_CNT_EN
   localparam int SEU_10  = 10;
   localparam int SEU_MAX = 255;
`else
   localparam int SEU_10  = 0;
   localparam int SEU_MAX = 0;
`endif

   adc_ctrl_rx #(.PUP_WAIT(4), .CAL_PULSE(2), .CAL_START_TO(8), .CAL_TIMEOUT(50)) dut (
      .CLK(CLK), .RST(RST), .en(en), .cal_req(cal_req), .df_twos(df_twos),
      .adc_d(adc_d), .adc_ovf(adc_ovf), .adc_cal_busy(adc_cal_busy), .adc_seu(adc_seu),
      .OM_A(OM_A), .OM_B(OM_B), .OM_C(OM_C), .CAL_A(CAL_A), .CAL_B(CAL_B), .CAL_C(CAL_C),
      .DF_A(DF_A), .DF_B(DF_B), .DF_C(DF_C), .data_out(data_out), .data_valid(data_valid),
      .ovf_out(ovf_out), .ready(ready), .error(error), .seu_count(seu_count)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   wire [2:0] om_bus  = {OM_A, OM_B, OM_C};
   wire [2:0] cal_bus = {CAL_A, CAL_B, CAL_C};
   wire [2:0] df_bus  = {DF_A, DF_B, DF_C};

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [11:0] d, input logic o, input logic [11:0] ed, input logic eo);
      exp_t e;
      adc_d   = d;
      adc_ovf = o;
      e.cyc = cyc + 2;
      e.d   = ed;
      e.ovf = eo;
      sb_q.push_back(e);
      step(1);
   endtask

   // Steps until a CAL pulse has been seen and released; reports pulse width.
   task automatic cal_release(input string name);
      int width = 0;
      bit seen  = 0;
      bit done  = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (CAL_A) begin
            seen = 1;
            width++;
         end else if (seen) begin
            done = 1;
         end
         if (!done) step(1);
      end
      check({name, " cal released"}, 64'(done), 64'd1);
      check({name, " cal width"}, 64'(width), 64'd2);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t e;
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         n_checks++;
         if ({data_valid, ovf_out, data_out} !== {1'b1, e.ovf, e.d}) begin
            n_fail++;
            $display("FAIL sample@%0d: got valid=%b ovf=%b data=%h expected valid=1 ovf=%b data=%h",
                     cyc, data_valid, ovf_out, data_out, e.ovf, e.d);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; en = 1'b0; cal_req = 1'b0; df_twos = 1'b0; adc_ovf = 1'b0;
      adc_cal_busy = 1'b0; adc_seu = 1'b0; adc_d = 12'h000;
      #1 RST = 1'b1;
      #1;
      check("reset outputs", {om_bus, cal_bus, df_bus, data_out, data_valid, ovf_out, ready, error, seu_count}, 64'd0);
      step(2);
      RST = 1'b0;
      df_twos = 1'b1;
      step(1);
      check("df latched in off", df_bus, 3'b111);
      check("om off", om_bus, 3'b000);

      // Power-up sequence with exact timing
      en = 1'b1;
      step(1);
      check("om after en", om_bus, 3'b111);
      check("cal low at pwrup", cal_bus, 3'b000);
      step(3);
      check("cal low end pwrup", cal_bus, 3'b000);
      step(1);
      check("cal rise", cal_bus, 3'b111);
      step(1);
      check("cal second cycle", cal_bus, 3'b111);
      step(1);
      check("cal fall", cal_bus, 3'b000);
      step(2);
      adc_cal_busy = 1'b1;
      step(20);
      check("not ready while busy", ready, 1'b0);
      adc_cal_busy = 1'b0;
      step(1);
      check("ready after busy falls", ready, 1'b1);
      check("valid after busy falls", data_valid, 1'b1);
      check("no error after cal", error, 1'b0);

      // Data path, two's complement input converted to offset binary
      send(12'h000, 1'b0, 12'h800, 1'b0);
      send(12'hFFF, 1'b1, 12'h7FF, 1'b1);
      send(12'h123, 1'b0, 12'h923, 1'b0);
      send(12'h8A5, 1'b1, 12'h0A5, 1'b1);
      send(12'h7FF, 1'b0, 12'hFFF, 1'b0);
      adc_ovf = 1'b0;
      step(3);
      check("scoreboard drained 1", sb_q.size(), 0);

      // Recalibration on request; request during CAL_WAIT_LO ignored
      cal_req = 1'b1;
      step(1);
      cal_req = 1'b0;
      check("recal valid drop", data_valid, 1'b0);
      check("recal ready drop", ready, 1'b0);
      cal_release("recal");
      step(2);
      adc_cal_busy = 1'b1;
      step(1);
      cal_req = 1'b1;
      step(1);
      cal_req = 1'b0;
      check("cal_req ignored in wait_lo", cal_bus, 3'b000);
      step(4);
      adc_cal_busy = 1'b0;
      step(1);
      check("ready after recal", ready, 1'b1);

      // cal_req and busy together in RUN: cal_req wins
      cal_req = 1'b1;
      adc_cal_busy = 1'b1;
      step(1);
      cal_req = 1'b0;
      adc_cal_busy = 1'b0;
      check("cal_req beats busy", cal_bus, 3'b111);
      cal_release("simul");
      step(2);
      adc_cal_busy = 1'b1;
      step(3);
      adc_cal_busy = 1'b0;
      step(1);
      check("ready after simul", ready, 1'b1);

      // Unsolicited calibration in RUN
      adc_cal_busy = 1'b1;
      step(1);
      check("unsolicited not ready", {ready, data_valid, cal_bus}, 5'b00000);
      adc_cal_busy = 1'b0;
      step(1);
      check("unsolicited back to run", ready, 1'b1);

      // Timeout waiting for busy to rise
      cal_req = 1'b1;
      step(1);
      cal_req = 1'b0;
      cal_release("start_to");
      step(7);
      check("no error before start timeout", error, 1'b0);
      step(1);
      check("start timeout error", error, 1'b1);
      check("err not ready", ready, 1'b0);
      check("err om cal", {om_bus, cal_bus}, 6'b111000);

      // Retry from ERR, then busy stuck high
      cal_req = 1'b1;
      step(1);
      cal_req = 1'b0;
      check("retry clears error", error, 1'b0);
      cal_release("retry");
      step(2);
      adc_cal_busy = 1'b1;
      step(1);
      step(49);
      check("no error before busy timeout", error, 1'b0);
      step(1);
      check("busy timeout error", error, 1'b1);
      adc_cal_busy = 1'b0;

      // Busy edge coincides with start timeout: the edge wins
      cal_req = 1'b1;
      step(1);
      cal_req = 1'b0;
      cal_release("edge_wins");
      step(7);
      adc_cal_busy = 1'b1;
      step(1);
      check("edge beats timeout", error, 1'b0);
      adc_cal_busy = 1'b0;
      step(1);
      check("run after edge", ready, 1'b1);

      // en abort from RUN
      en = 1'b0;
      step(1);
      check("en abort outputs", {om_bus, cal_bus, ready, error}, 8'd0);

      // Offset-binary input passes through; DF frozen while powered
      df_twos = 1'b0;
      step(1);
      check("df cleared in off", df_bus, 3'b000);
      en = 1'b1;
      cal_release("pwrup2");
      step(2);
      adc_cal_busy = 1'b1;
      step(3);
      adc_cal_busy = 1'b0;
      step(1);
      check("ready pwrup2", ready, 1'b1);
      df_twos = 1'b1;
      step(1);
      check("df frozen while om", df_bus, 3'b000);
      send(12'h800, 1'b0, 12'h800, 1'b0);
      send(12'h5A5, 1'b1, 12'h5A5, 1'b1);
      adc_ovf = 1'b0;
      step(3);
      check("scoreboard drained 2", sb_q.size(), 0);

      // Asynchronous reset during CAL_WAIT_LO
      cal_req = 1'b1;
      step(1);
      cal_req = 1'b0;
      cal_release("rst");
      step(2);
      adc_cal_busy = 1'b1;
      step(1);
      check("om before reset", om_bus, 3'b111);
      #2 RST = 1'b1;
      #1;
      check("async reset outputs", {om_bus, cal_bus, df_bus, data_out, data_valid, ovf_out, ready, error, seu_count}, 64'd0);
      adc_cal_busy = 1'b0;
      en = 1'b0;
      step(1);
      RST = 1'b0;
      step(1);
      check("off after reset", om_bus, 3'b000);

      // SEU counting and saturation
      for (int i = 0; i < 10; i++) begin
         adc_seu = 1'b1;
         step(1);
         adc_seu = 1'b0;
         step(1);
      end
      step(3);
      check("seu count 10", seu_count, 8'(SEU_10));
      for (int i = 0; i < 290; i++) begin
         adc_seu = 1'b1;
         step(1);
         adc_seu = 1'b0;
         step(1);
      end
      step(3);
      check("seu count saturated", seu_count, 8'(SEU_MAX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
